// File: rtl/approx_mul_pkg.sv
// Shared widths, FSM encoding and row weighting for the approximate multiplier sequencer.
// Pure definitions: no latency and no flow control.
package approx_mul_pkg;

    localparam int ROW_T_W  = 9;
    localparam int ROW_B_W  = 7;
    localparam int NUM_ROWS = 4;
    localparam int ACC_W    = 17;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ACC  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Row k covers multiplicand bits 2k and 2k+1, so its weight is 4^k.
    function automatic logic [ACC_W-1:0] row_value(
        input logic [ROW_T_W-1:0] t,
        input logic [ROW_B_W-1:0] b,
        input logic [1:0]         k
    );
        logic [ACC_W-1:0] base;
        base = ACC_W'(t) + (ACC_W'(b) << 2);
        return base << {k, 1'b0};
    endfunction

endpackage

// File: rtl/approx_row_weigher.sv
// Weighted sum of one group of ROWS_PER_CYCLE array rows, selected by the group index.
// Combinational, zero latency; no flow control.
module approx_row_weigher
    import approx_mul_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic [NUM_ROWS*ROW_B_W-1:0] row_b,
    input  logic [NUM_ROWS*ROW_T_W-1:0] row_t,
    input  logic [1:0]                  grp,
    output logic [ACC_W-1:0]            grp_sum
);

    always_comb begin
        int k;
        k       = 0;
        grp_sum = '0;
        for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
            k = int'(grp) * ROWS_PER_CYCLE + r;
            if (k < NUM_ROWS) begin
                grp_sum = grp_sum + row_value(row_t[ROW_T_W*k +: ROW_T_W],
                                              row_b[ROW_B_W*k +: ROW_B_W],
                                              2'(k));
            end
        end
    end

endmodule

// File: rtl/approx_mul_row_sequencer.sv
// Latches an operand pair, accumulates the array rows ROWS_PER_CYCLE at a time, presents the product.
// out_valid follows acceptance by 4/ROWS_PER_CYCLE cycles; product is held while out_ready is low.
module approx_mul_row_sequencer
    import approx_mul_pkg::*;
#(
    parameter int ROWS_PER_CYCLE = 1,
    parameter bit SATURATE       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [7:0]  arr_x,
    output logic [7:0]  arr_y,
    input  logic [27:0] row_b,
    input  logic [35:0] row_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        ovf
);

    localparam int         NGRP     = NUM_ROWS / ROWS_PER_CYCLE;
    localparam logic [1:0] LAST_GRP = 2'(NGRP - 1);

    if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rows
        $error("ROWS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t           state;
    logic [7:0]       x_q;
    logic [7:0]       y_q;
    logic [ACC_W-1:0] acc;
    logic [1:0]       grp;
    logic [15:0]      p_q;
    logic             ovf_q;
    logic [ACC_W-1:0] grp_sum;
    logic [ACC_W-1:0] acc_next;
    logic [15:0]      p_final;

    approx_row_weigher #(
        .ROWS_PER_CYCLE(ROWS_PER_CYCLE)
    ) u_weigher (
        .row_b  (row_b),
        .row_t  (row_t),
        .grp    (grp),
        .grp_sum(grp_sum)
    );

    // The full 4-row sum tops out at 86615, so 17 bits never wrap.
    assign acc_next = acc + grp_sum;
    assign p_final  = (SATURATE && acc_next[ACC_W-1]) ? 16'hFFFF : acc_next[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x_q   <= '0;
            y_q   <= '0;
            acc   <= '0;
            grp   <= '0;
            p_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q   <= x;
                        y_q   <= y;
                        acc   <= '0;
                        grp   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (grp == LAST_GRP) begin
                        grp   <= '0;
                        p_q   <= p_final;
                        ovf_q <= acc_next[ACC_W-1];
                        state <= DONE;
                    end else begin
                        grp <= grp + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is masked by rst so the block never advertises acceptance while held in reset.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign arr_x     = x_q;
    assign arr_y     = y_q;
    assign p         = p_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_approx_mul_row_sequencer.sv
// Directed bench: four sequencer builds (R=1/2/4 saturating, R=1 wrapping) share the operand stream.
// A behavioural array stub answers each build's arr_x/arr_y with row vectors.
module tb_approx_mul_row_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        out_ready;
    logic        synth;

    logic        in_ready_1, in_ready_2, in_ready_4, in_ready_w;
    logic [7:0]  arr_x_1, arr_x_2, arr_x_4, arr_x_w;
    logic [7:0]  arr_y_1, arr_y_2, arr_y_4, arr_y_w;
    logic [27:0] row_b_1, row_b_2, row_b_4, row_b_w;
    logic [35:0] row_t_1, row_t_2, row_t_4, row_t_w;
    logic        out_valid_1, out_valid_2, out_valid_4, out_valid_w;
    logic [15:0] p_1, p_2, p_4, p_w;
    logic        ovf_1, ovf_2, ovf_4, ovf_w;

    int checks;
    int errors;

    int          lat1, lat2, lat4, latw;
    logic [15:0] pr1, pr2, pr4, prw;
    logic        of1, of2, of4, ofw;
    logic [15:0] held_p;
    logic        seen;

    // Row k = {b, t}. Synthetic mode drives all-ones; (FF,01) and (01,FF) reproduce the
    // production array's approximate rows; any other pair gets an exact decomposition.
    function automatic logic [15:0] row_enc(input logic [7:0] ax, input logic [7:0] ay,
                                            input int k, input logic syn);
        logic [1:0] pr;
        logic [9:0] v;
        if (syn) return {7'h7F, 9'h1FF};
        if (ax == 8'hFF && ay == 8'h01) return {7'd0, (k == 0 || k == 3) ? 9'd3 : 9'd1};
        if (ax == 8'h01 && ay == 8'hFF) return (k == 0) ? {7'd9, 9'd255} : 16'd0;
        pr = ax[2*k +: 2];
        v  = {8'b0, pr} * {2'b0, ay};
        if (v < 10'd512) return {7'd0, v[8:0]};
        v = v - 10'd508;
        return {7'd127, v[8:0]};
    endfunction

    function automatic logic [63:0] stub(input logic [7:0] ax, input logic [7:0] ay,
                                         input logic syn);
        logic [27:0] bb;
        logic [35:0] tt;
        logic [15:0] r;
        bb = '0;
        tt = '0;
        for (int k = 0; k < 4; k++) begin
            r = row_enc(ax, ay, k, syn);
            bb[7*k +: 7] = r[15:9];
            tt[9*k +: 9] = r[8:0];
        end
        return {bb, tt};
    endfunction

    assign {row_b_1, row_t_1} = stub(arr_x_1, arr_y_1, synth);
    assign {row_b_2, row_t_2} = stub(arr_x_2, arr_y_2, synth);
    assign {row_b_4, row_t_4} = stub(arr_x_4, arr_y_4, synth);
    assign {row_b_w, row_t_w} = stub(arr_x_w, arr_y_w, synth);

    approx_mul_row_sequencer #(.ROWS_PER_CYCLE(1), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1), .x(x), .y(y),
        .arr_x(arr_x_1), .arr_y(arr_y_1), .row_b(row_b_1), .row_t(row_t_1),
        .out_valid(out_valid_1), .out_ready(out_ready), .p(p_1), .ovf(ovf_1));

    approx_mul_row_sequencer #(.ROWS_PER_CYCLE(2), .SATURATE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2), .x(x), .y(y),
        .arr_x(arr_x_2), .arr_y(arr_y_2), .row_b(row_b_2), .row_t(row_t_2),
        .out_valid(out_valid_2), .out_ready(out_ready), .p(p_2), .ovf(ovf_2));

    approx_mul_row_sequencer #(.ROWS_PER_CYCLE(4), .SATURATE(1'b1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_4), .x(x), .y(y),
        .arr_x(arr_x_4), .arr_y(arr_y_4), .row_b(row_b_4), .row_t(row_t_4),
        .out_valid(out_valid_4), .out_ready(out_ready), .p(p_4), .ovf(ovf_4));

    approx_mul_row_sequencer #(.ROWS_PER_CYCLE(1), .SATURATE(1'b0)) dutw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .x(x), .y(y),
        .arr_x(arr_x_w), .arr_y(arr_y_w), .row_b(row_b_w), .row_t(row_t_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .p(p_w), .ovf(ovf_w));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle operand pulse while every build is idle, then a bounded watch of all four outputs.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        x        = a;
        y        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat1 = 0; lat2 = 0; lat4 = 0; latw = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_1 && lat1 == 0) begin lat1 = c; pr1 = p_1; of1 = ovf_1; end
            if (out_valid_2 && lat2 == 0) begin lat2 = c; pr2 = p_2; of2 = ovf_2; end
            if (out_valid_4 && lat4 == 0) begin lat4 = c; pr4 = p_4; of4 = ovf_4; end
            if (out_valid_w && latw == 0) begin latw = c; prw = p_w; ofw = ovf_w; end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = 8'h00;
        y         = 8'h00;
        out_ready = 1'b1;
        synth     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_1, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready_1, 1);
        chk("post_rst_out_valid", out_valid_1, 0);
        chk("post_rst_p", p_1, 0);
        chk("post_rst_ovf", ovf_1, 0);
        chk("post_rst_arr_x", arr_x_1, 0);
        chk("post_rst_arr_y", arr_y_1, 0);

        run_op(8'h00, 8'hA5);
        chk("zero_p", pr1, 16'h0000);
        chk("zero_ovf", of1, 0);
        chk("zero_lat_r1", lat1, 4);
        chk("zero_lat_r2", lat2, 2);
        chk("zero_lat_r4", lat4, 1);
        chk("zero_lat_wrap", latw, 4);

        run_op(8'hFF, 8'h01);
        chk("ff01_p_r1", pr1, 16'h00D7);
        chk("ff01_ovf_r1", of1, 0);
        chk("ff01_lat_r1", lat1, 4);
        chk("ff01_p_r4", pr4, 16'h00D7);

        run_op(8'h01, 8'hFF);
        chk("01ff_p_r1", pr1, 16'h0123);
        chk("01ff_p_r2", pr2, 16'h0123);
        chk("01ff_p_r4", pr4, 16'h0123);
        chk("01ff_ovf_r1", of1, 0);

        synth = 1'b1;
        run_op(8'h5A, 8'hC3);
        synth = 1'b0;
        chk("sat_p_r1", pr1, 16'hFFFF);
        chk("sat_ovf_r1", of1, 1);
        chk("sat_p_r2", pr2, 16'hFFFF);
        chk("sat_p_r4", pr4, 16'hFFFF);
        chk("wrap_p", prw, 16'h5257);
        chk("wrap_ovf", ofw, 1);

        // Backpressure: 18*52 = 936 held in DONE while out_ready is low.
        out_ready = 1'b0;
        @(negedge clk);
        x        = 8'h12;
        y        = 8'h34;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        x = 8'h77;
        y = 8'h11;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = out_valid_1;
        end
        chk("bp_reach_done", seen, 1);
        chk("bp_p", p_1, 16'd936);
        held_p = p_1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", out_valid_1, 1);
            chk("bp_hold_p", p_1, held_p);
            chk("bp_hold_ovf", ovf_1, 0);
            chk("bp_in_ready", in_ready_1, 0);
            chk("bp_arr_x", arr_x_1, 8'h12);
        end
        x         = 8'h05;
        y         = 8'h07;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid_1, 0);
        chk("bp_release_ready", in_ready_1, 1);
        chk("bp_release_arr_x", arr_x_1, 8'h12);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_accept_arr_x", arr_x_1, 8'h05);
        chk("bp_next_busy", in_ready_1, 0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = out_valid_1;
        end
        chk("bp_next_done", seen, 1);
        chk("bp_next_p", p_1, 16'd35);
        repeat (6) @(posedge clk);
        #1;

        // Abort: reset lands while the R=1 build is at grp=1.
        @(negedge clk);
        x        = 8'h55;
        y        = 8'h66;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rst_in_ready", in_ready_1, 0);
        rst = 1'b0;
        #1;
        chk("abort_after_in_ready", in_ready_1, 1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid_1 | out_valid_2 | out_valid_4 | out_valid_w;
        end
        chk("abort_no_product", seen, 0);

        run_op(8'h03, 8'h03);
        chk("abort_next_p_r1", pr1, 16'd9);
        chk("abort_next_p_r2", pr2, 16'd9);
        chk("abort_next_p_r4", pr4, 16'd9);
        chk("abort_next_lat_r1", lat1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
